car_sequencer: RTL

CAR_SEQUENCER -- requirements
Module: car_sequencer

---
 rtl/car_sequencer_pkg.sv | 94 +++++++++
 rtl/car_sequencer_dispatch.sv | 63 ++++++
 rtl/car_sequencer.sv | 56 +++++
 3 files changed

// File: rtl/car_sequencer_pkg.sv
// Shared control-sequencer definitions: CAR encodings, register numbers,
// opcode field constants and small decode helpers used by the sequencer
// and the ControlUnit.
package car_sequencer_pkg;

    localparam int unsigned CAR_W = 6;

    // Register numbers as they appear in the source/destination fields
    localparam logic [3:0] REG_PC = 4'd0;
    localparam logic [3:0] REG_SP = 4'd1;
    localparam logic [3:0] REG_SR = 4'd2;
    localparam logic [3:0] REG_R3 = 4'd3;

    // Opcode field constants
    localparam logic [2:0] OPC_JMP      = 3'b001;  // IR[15:13]
    localparam logic [5:0] OPC_FMT2     = 6'b000100; // IR[15:10]
    localparam logic [3:0] OPC_FMT1_MIN = 4'h4;    // IR[15:12] lower bound
    localparam logic [2:0] F2_PUSH      = 3'b100;  // IR[9:7]
    localparam logic [2:0] F2_CALL      = 3'b101;
    localparam logic [2:0] F2_RETI      = 3'b110;
    localparam logic [2:0] F2_ILL       = 3'b111;

    typedef enum logic [1:0] {
        CLS_REG,
        CLS_IDX,
        CLS_IND
    } src_class_e;

    // Each multi-state sequence occupies consecutive codes so that the
    // non-terminal states simply advance by one.
    typedef enum logic [CAR_W-1:0] {
        CAR_0 = 6'd0,
        CAR_REG_REG,
        CAR_REG_IDX0, CAR_REG_IDX1, CAR_REG_IDX2, CAR_REG_IDX3,
        CAR_IND_REG0, CAR_IND_REG1,
        CAR_IND_IDX0, CAR_IND_IDX1, CAR_IND_IDX2, CAR_IND_IDX3, CAR_IND_IDX4,
        CAR_IDX_REG0, CAR_IDX_REG1, CAR_IDX_REG2,
        CAR_IDX_IDX0, CAR_IDX_IDX1, CAR_IDX_IDX2, CAR_IDX_IDX3, CAR_IDX_IDX4,
        CAR_IDX_IDX5,
        CAR_1OP_REG,
        CAR_1OP_IND0, CAR_1OP_IND1, CAR_1OP_IND2,
        CAR_1OP_IDX0, CAR_1OP_IDX1, CAR_1OP_IDX2, CAR_1OP_IDX3,
        CAR_PUSH_REG0, CAR_PUSH_REG1, CAR_PUSH_REG2,
        CAR_PUSH_IND0, CAR_PUSH_IND1, CAR_PUSH_IND2,
        CAR_PUSH_IDX0, CAR_PUSH_IDX1, CAR_PUSH_IDX2, CAR_PUSH_IDX3,
        CAR_CALL_REG0, CAR_CALL_REG1, CAR_CALL_REG2,
        CAR_CALL_IND0, CAR_CALL_IND1, CAR_CALL_IND2,
        CAR_CALL_IDX0, CAR_CALL_IDX1, CAR_CALL_IDX2, CAR_CALL_IDX3,
        CAR_RETI0, CAR_RETI1, CAR_RETI2, CAR_RETI3,
        CAR_INT0, CAR_INT1, CAR_INT2, CAR_INT3, CAR_INT4,
        CAR_JMP0
    } car_e;

    // Source operand class; the constant generator (R3 always, R2 with
    // indirect modes) needs no operand fetch and counts as register mode.
    function automatic src_class_e src_class(input logic [3:0] sreg,
                                             input logic [1:0] as);
        if (sreg == REG_R3 || (sreg == REG_SR && as[1]))
            return CLS_REG;
        case (as)
            2'b00:   return CLS_REG;
            2'b01:   return CLS_IDX;
            default: return CLS_IND;
        endcase
    endfunction

    // States at which the next instruction (or interrupt) is dispatched
    function automatic logic is_dispatch(input car_e c);
        case (c)
            CAR_0, CAR_REG_REG, CAR_REG_IDX3, CAR_IND_REG1, CAR_IND_IDX4,
            CAR_IDX_REG2, CAR_IDX_IDX5, CAR_1OP_REG, CAR_1OP_IND2,
            CAR_1OP_IDX3, CAR_PUSH_REG2, CAR_PUSH_IND2, CAR_PUSH_IDX3:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

    // Terminal states of control-transfer sequences; they refetch via CAR_0
    function automatic logic is_flush(input car_e c);
        case (c)
            CAR_JMP0, CAR_CALL_REG2, CAR_CALL_IND2, CAR_CALL_IDX3,
            CAR_RETI3, CAR_INT4:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

    function automatic logic is_valid(input car_e c);
        return c <= CAR_JMP0;
    endfunction

endpackage

// File: rtl/car_sequencer_dispatch.sv
// Combinational instruction decode: maps the instruction word to the first
// control state of its microsequence and flags unsupported encodings.
module car_dispatch
    import car_sequencer_pkg::*;
(
    input  logic [15:0] IR,
    output car_e        target,
    output logic        illegal
);

    src_class_e f1_cls;
    src_class_e f2_cls;
    logic       unused_ir_bw;

    assign f1_cls = src_class(IR[11:8], IR[5:4]);
    assign f2_cls = src_class(IR[3:0], IR[5:4]);
    // Byte/word select does not change the microsequence
    assign unused_ir_bw = IR[6];

    // Select the first state of the sequence implied by the opcode format
    always_comb begin
        target  = CAR_0;
        illegal = 1'b1;
        if (IR[15:13] == OPC_JMP) begin
            target  = CAR_JMP0;
            illegal = 1'b0;
        end else if (IR[15:12] >= OPC_FMT1_MIN) begin
            illegal = 1'b0;
            case (f1_cls)
                CLS_REG: target = IR[7] ? CAR_REG_IDX0 : CAR_REG_REG;
                CLS_IDX: target = IR[7] ? CAR_IDX_IDX0 : CAR_IDX_REG0;
                default: target = IR[7] ? CAR_IND_IDX0 : CAR_IND_REG0;
            endcase
        end else if (IR[15:10] == OPC_FMT2 && IR[9:7] != F2_ILL) begin
            illegal = 1'b0;
            case (IR[9:7])
                F2_PUSH: begin
                    case (f2_cls)
                        CLS_REG: target = CAR_PUSH_REG0;
                        CLS_IDX: target = CAR_PUSH_IDX0;
                        default: target = CAR_PUSH_IND0;
                    endcase
                end
                F2_CALL: begin
                    case (f2_cls)
                        CLS_REG: target = CAR_CALL_REG0;
                        CLS_IDX: target = CAR_CALL_IDX0;
                        default: target = CAR_CALL_IND0;
                    endcase
                end
                F2_RETI: target = CAR_RETI0;
                default: begin
                    case (f2_cls)
                        CLS_REG: target = CAR_1OP_REG;
                        CLS_IDX: target = CAR_1OP_IDX0;
                        default: target = CAR_1OP_IND0;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: rtl/car_sequencer.sv
// Control address register sequencer: Moore FSM whose state is the CAR
// driving the ControlUnit. Walks each instruction's microsequence, takes
// interrupts only at dispatch states, and honours memory stalls.
module car_sequencer
    import car_sequencer_pkg::*;
#(
    parameter int unsigned CAR_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         IR,
    input  logic                INTREQ,
    input  logic                Stall,
    output logic [CAR_BITS-1:0] CAR,
    output logic                Dispatch,
    output logic                Illegal
);

    car_e state;
    car_e dispatch_target;
    logic dispatch_illegal;

    car_dispatch u_dispatch (
        .IR      (IR),
        .target  (dispatch_target),
        .illegal (dispatch_illegal)
    );

    assign CAR      = CAR_BITS'(state);
    assign Dispatch = is_dispatch(state);

    // Sequencer state and registered illegal-opcode pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CAR_0;
            Illegal <= 1'b0;
        end else if (Stall) begin
            Illegal <= 1'b0;
        end else begin
            Illegal <= 1'b0;
            if (is_dispatch(state)) begin
                if (INTREQ) begin
                    state <= CAR_INT0;
                end else begin
                    state   <= dispatch_target;
                    Illegal <= dispatch_illegal;
                end
            end else if (is_flush(state) || !is_valid(state)) begin
                state <= CAR_0;
            end else begin
                state <= car_e'(state + 6'd1);
            end
        end
    end

endmodule
